// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_pkg
//  Description : Shared types and constants for the mastermind game sequencer:
//                FSM state encodings, LED colours, LFSR seed/taps, score width.
//  Revision    : 1.0  initial release
// ============================================================================
package mastermind_pkg;

   typedef enum logic [2:0] {
      S_CODE  = 3'd0,
      S_PLAY  = 3'd1,
      S_SCORE = 3'd2,
      S_WIN   = 3'd3,
      S_LOSE  = 3'd4
   } state_t;

   // LED colour codes used by the display side of the game
   localparam logic [1:0] RED = 2'd0;
   localparam logic [1:0] YLW = 2'd1;
   localparam logic [1:0] BLU = 2'd2;
   localparam logic [1:0] GRN = 2'd3;

   // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int SCORE_W = 8;
   localparam logic [SCORE_W-1:0] WIN_POSITIONS = 8'd4;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mastermind_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_game_ctrl_if
//  Description : Bus between the game sequencer and the guess source / scorer.
//                master = sequencer side, slave = surrounding logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface mastermind_game_ctrl_if #(
   parameter int TURN_W = 4
) ();
   import mastermind_pkg::*;

   logic [15:0]        guess_i;
   logic [SCORE_W-1:0] positions_matched_i;
   logic [SCORE_W-1:0] numbers_matched_i;
   logic [15:0]        code_o;
   logic [15:0]        guess_o;
   logic               score_valid_o;
   logic [SCORE_W-1:0] positions_o;
   logic [SCORE_W-1:0] numbers_o;
   logic [TURN_W-1:0]  turn_o;
   logic [2:0]         state_o;
   logic               lock_o;
   logic               lose_o;

   modport master (
      input  guess_i, positions_matched_i, numbers_matched_i,
      output code_o, guess_o, score_valid_o, positions_o, numbers_o,
             turn_o, state_o, lock_o, lose_o
   );

   modport slave (
      output guess_i, positions_matched_i, numbers_matched_i,
      input  code_o, guess_o, score_valid_o, positions_o, numbers_o,
             turn_o, state_o, lock_o, lose_o
   );

endinterface
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce
//  Description : Two-flop synchroniser plus counter debouncer for a raw
//                pushbutton. press_o pulses for one cycle on each debounced
//                rising edge; level_o is the debounced level.
//  Revision    : 1.0  initial release
// ============================================================================
module pb_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_i,
   output logic press_o,
   output logic level_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             stable;
   logic [CNT_W-1:0] count;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= pb_i;
         sync_b <= sync_a;
      end
   end

   // Count how long the synchronised level has differed from the stable one;
   // any return to the stable level restarts the count, so a change is only
   // accepted after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable  <= 1'b0;
         count   <= '0;
         press_o <= 1'b0;
      end else begin
         press_o <= 1'b0;
         if (sync_b == stable) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            stable  <= sync_b;
            count   <= '0;
            press_o <= sync_b;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign level_o = stable;

endmodule
`default_nettype wire

// File: rtl/mastermind_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_game_ctrl
//  Description : Game sequencer: debounces the button, captures the secret
//                code, latches guesses for the scorer, samples the score,
//                counts turns and declares win/lose.
//                Optional macro MM_AUTOCODE_EN: secret code taken from a
//                free-running LFSR instead of the switches.
//  Revision    : 1.0  initial release
// ============================================================================
module mastermind_game_ctrl
   import mastermind_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_TURNS       = 10,
   parameter int TURN_W          = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pb_i,
   mastermind_game_ctrl_if.master bus
);

   localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(MAX_TURNS);

   state_t             state;
   state_t             state_next;
   logic               press_raw;
   logic               pb_level;
   logic               press;
   logic [15:0]        new_code;
   logic [15:0]        code;
   logic [15:0]        guess;
   logic [SCORE_W-1:0] positions;
   logic [SCORE_W-1:0] numbers;
   logic [TURN_W-1:0]  turn;
   logic [TURN_W-1:0]  turn_inc;
   logic               score_valid;

   pb_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_pb_debounce (
      .clk     (clk),
      .rst     (rst),
      .pb_i    (pb_i),
      .press_o (press_raw),
      .level_o (pb_level)
   );

   // A press is only honoured while the debounced level is high
   assign press    = press_raw & pb_level;
   assign turn_inc = turn + 1'b1;

`ifdef MM_AUTOCODE_EN
   logic [15:0] lfsr;

   // Free-running code generator; a nonzero seed keeps it off the all-zero lockup
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end

   assign new_code = lfsr;
`else
   assign new_code = bus.guess_i;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_CODE;
      else     state <= state_next;
   end

   // Next-state logic; a win on the last turn beats the lose condition
   always_comb begin
      state_next = state;
      case (state)
         S_CODE:  if (press) state_next = S_PLAY;
         S_PLAY:  if (press) state_next = S_SCORE;
         S_SCORE: begin
            if (bus.positions_matched_i >= WIN_POSITIONS) state_next = S_WIN;
            else if (turn_inc == LAST_TURN)               state_next = S_LOSE;
            else                                          state_next = S_PLAY;
         end
         S_WIN, S_LOSE: if (press) state_next = S_CODE;
         default: state_next = S_CODE;
      endcase
   end

   // Game datapath: code/guess capture, score sampling, turn counting.
   // Presses arriving in S_SCORE fall through the case and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         code        <= '0;
         guess       <= '0;
         positions   <= '0;
         numbers     <= '0;
         turn        <= '0;
         score_valid <= 1'b0;
      end else begin
         score_valid <= (state == S_SCORE);
         case (state)
            S_CODE: begin
               if (press) begin
                  code      <= new_code;
                  turn      <= '0;
                  positions <= '0;
                  numbers   <= '0;
               end
            end
            S_PLAY: begin
               if (press) guess <= bus.guess_i;
            end
            S_SCORE: begin
               positions <= bus.positions_matched_i;
               numbers   <= bus.numbers_matched_i;
               turn      <= turn_inc;
            end
            default: ;
         endcase
      end
   end

   assign bus.code_o        = code;
   assign bus.guess_o       = guess;
   assign bus.score_valid_o = score_valid;
   assign bus.positions_o   = positions;
   assign bus.numbers_o     = numbers;
   assign bus.turn_o        = turn;
   assign bus.state_o       = state;
   assign bus.lock_o        = (state == S_WIN);
   assign bus.lose_o        = (state == S_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_mastermind_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_game_ctrl
//  Description : Self-checking bench for mastermind_game_ctrl with a
//                press-level game model and a behavioural scorer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mastermind_game_ctrl;

   localparam int D  = 4;
   localparam int MT = 3;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pb  = 1'b0;
   logic [15:0] gin = 16'h0;

   bit         use_forced = 1'b1;
   logic [7:0] f_pos = 8'd0;
   logic [7:0] f_num = 8'd0;
   logic [15:0] sc;

   int checks = 0;
   int errors = 0;
   int valid_cycles = 0;

   // game model
   int          m_state;
   logic [15:0] m_code, m_guess;
   int          m_turn, m_pos, m_num, m_valid;

   always #5 clk = ~clk;

   mastermind_game_ctrl_if #(.TURN_W(TW)) bus ();

   mastermind_game_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .MAX_TURNS       (MT),
      .TURN_W          (TW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .pb_i (pb),
      .bus  (bus.master)
   );

   assign bus.guess_i = gin;

   // Mastermind scoring of 4 nibbles: {exact matches, colour-only matches}
   function automatic logic [15:0] score(input logic [15:0] c, input logic [15:0] g);
      int p, tot;
      int cc[16];
      int gc[16];
      p = 0; tot = 0;
      for (int k = 0; k < 16; k++) begin cc[k] = 0; gc[k] = 0; end
      for (int i = 0; i < 4; i++) begin
         if (c[4*i +: 4] == g[4*i +: 4]) p++;
         cc[c[4*i +: 4]]++;
         gc[g[4*i +: 4]]++;
      end
      for (int k = 0; k < 16; k++) tot += (cc[k] < gc[k]) ? cc[k] : gc[k];
      return {8'(p), 8'(tot - p)};
   endfunction

   always_comb begin
      sc = score(bus.code_o, bus.guess_o);
      bus.positions_matched_i = use_forced ? f_pos : sc[15:8];
      bus.numbers_matched_i   = use_forced ? f_num : sc[7:0];
   end

   always @(posedge clk) begin
      if (rst)                    valid_cycles <= 0;
      else if (bus.score_valid_o) valid_cycles <= valid_cycles + 1;
   end

`ifdef MM_AUTOCODE_EN
   logic [15:0] lfsr_m, lfsr_prev, auto_code;
   logic [2:0]  prev_st;
   always @(posedge clk) begin
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      lfsr_prev <= lfsr_m;
   end
   always @(negedge clk) begin
      prev_st <= bus.state_o;
      if (prev_st == 3'd0 && bus.state_o == 3'd1) auto_code <= lfsr_prev;
   end
`endif

   task automatic model_reset();
      m_state = 0; m_code = 16'h0; m_guess = 16'h0;
      m_turn = 0; m_pos = 0; m_num = 0; m_valid = 0;
   endtask

   task automatic model_press();
      logic [15:0] s;
      case (m_state)
         0: begin
`ifdef MM_AUTOCODE_EN
            m_code = auto_code;
`else
            m_code = gin;
`endif
            m_turn = 0; m_pos = 0; m_num = 0; m_state = 1;
         end
         1: begin
            m_guess = gin;
            s = score(m_code, m_guess);
            m_pos = use_forced ? int'(f_pos) : int'(s[15:8]);
            m_num = use_forced ? int'(f_num) : int'(s[7:0]);
            m_turn++;
            m_valid++;
            m_state = (m_pos >= 4) ? 3 : (m_turn == MT) ? 4 : 1;
         end
         default: m_state = 0;
      endcase
   endtask

   task automatic press();
      pb = 1'b1;
      repeat (12) @(negedge clk);
      pb = 1'b0;
      repeat (10) @(negedge clk);
      model_press();
   endtask

   task automatic test_reset();
      rst = 1'b1; pb = 1'b0; gin = 16'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o);
      end
      checks++;
      if ({bus.code_o, bus.guess_o, bus.positions_o, bus.numbers_o, bus.turn_o,
           bus.score_valid_o, bus.lock_o, bus.lose_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: code %h guess %h pos %0d num %0d turn %0d expected all 0",
                            bus.code_o, bus.guess_o, bus.positions_o, bus.numbers_o, bus.turn_o);
      end
      rst = 1'b0;
      model_reset();
      pb = 1'b1;
      repeat (2) @(negedge clk);
      pb = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd0) begin
         errors++; $display("FAIL short_pulse_state: got %0d expected 0", bus.state_o);
      end
   endtask

   task automatic test_code_entry();
      int lat;
      gin = 16'h1234; use_forced = 1'b1; f_pos = 8'd0; f_num = 8'd0;
      lat = 0;
      pb = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (lat == 0 && bus.state_o == 3'd1) lat = n;
      end
      pb = 1'b0;
      repeat (10) @(negedge clk);
      model_press();
      checks++;
      if (lat != D + 3) begin
         errors++; $display("FAIL press_latency: got %0d expected %0d", lat, D + 3);
      end
      checks++;
      if (bus.code_o !== m_code) begin
         errors++; $display("FAIL code_entry_code: got %h expected %h", bus.code_o, m_code);
      end
`ifndef MM_AUTOCODE_EN
      checks++;
      if (bus.code_o !== 16'h1234) begin
         errors++; $display("FAIL code_entry_switches: got %h expected 1234", bus.code_o);
      end
`endif
      checks++;
      if (bus.state_o !== 3'd1 || bus.turn_o !== 4'd0) begin
         errors++; $display("FAIL code_entry_state: state %0d turn %0d expected 1 0", bus.state_o, bus.turn_o);
      end
   endtask

   task automatic test_win();
      gin = 16'h1234; f_pos = 8'd4; f_num = 8'd0;
      press();
      checks++;
      if (bus.positions_o !== 8'(m_pos) || bus.turn_o !== 4'(m_turn)) begin
         errors++; $display("FAIL win_score: pos %0d turn %0d expected %0d %0d",
                            bus.positions_o, bus.turn_o, m_pos, m_turn);
      end
      checks++;
      if (bus.lock_o !== 1'b1 || bus.lose_o !== 1'b0 || bus.state_o !== 3'd3) begin
         errors++; $display("FAIL win_state: lock %b lose %b state %0d expected 1 0 3",
                            bus.lock_o, bus.lose_o, bus.state_o);
      end
      checks++;
      if (valid_cycles != m_valid) begin
         errors++; $display("FAIL win_valid_pulse: got %0d cycles expected %0d", valid_cycles, m_valid);
      end
      gin = 16'hBEEF;
      press();
      checks++;
      if (bus.state_o !== 3'd0 || bus.code_o !== m_code || bus.guess_o !== 16'h1234) begin
         errors++; $display("FAIL win_exit: state %0d code %h guess %h expected 0 %h 1234",
                            bus.state_o, bus.code_o, bus.guess_o, m_code);
      end
   endtask

   task automatic test_lose();
      gin = 16'h5678;
      press();
      f_pos = 8'd1; f_num = 8'd2;
      for (int k = 1; k <= MT; k++) begin
         gin = 16'($urandom);
         press();
         checks++;
         if (bus.turn_o !== 4'(k) || valid_cycles != m_valid) begin
            errors++; $display("FAIL lose_turn: turn %0d valid %0d expected %0d %0d",
                               bus.turn_o, valid_cycles, k, m_valid);
         end
      end
      checks++;
      if (bus.lose_o !== 1'b1 || bus.lock_o !== 1'b0 || bus.state_o !== 3'd4 || bus.numbers_o !== 8'd2) begin
         errors++; $display("FAIL lose_state: lose %b lock %b state %0d num %0d expected 1 0 4 2",
                            bus.lose_o, bus.lock_o, bus.state_o, bus.numbers_o);
      end
      press();
   endtask

   task automatic test_win_last_turn();
      gin = 16'h9A0F;
      press();
      f_pos = 8'd1; f_num = 8'd0;
      press();
      press();
      f_pos = 8'd4;
      press();
      checks++;
      if (bus.lock_o !== 1'b1 || bus.lose_o !== 1'b0 || bus.state_o !== 3'd3 || bus.turn_o !== 4'd3) begin
         errors++; $display("FAIL win_last_turn: lock %b lose %b state %0d turn %0d expected 1 0 3 3",
                            bus.lock_o, bus.lose_o, bus.state_o, bus.turn_o);
      end
      press();
   endtask

   task automatic test_bounce_in_score();
      bit found;
      gin = 16'h4321;
      press();
      f_pos = 8'd0; f_num = 8'd1;
      gin = 16'h1111;
      found = 1'b0;
      pb = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.state_o == 3'd2) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL bounce_reach_score: S_SCORE not seen within 30 cycles");
      end
      for (int n = 0; n < 10; n++) begin
         pb = ~pb;
         @(negedge clk);
      end
      pb = 1'b0;
      repeat (12) @(negedge clk);
      model_press();
      checks++;
      if (bus.turn_o !== 4'(m_turn) || bus.state_o !== 3'(m_state) || valid_cycles != m_valid) begin
         errors++; $display("FAIL bounce_no_extra_turn: turn %0d state %0d valid %0d expected %0d %0d %0d",
                            bus.turn_o, bus.state_o, valid_cycles, m_turn, m_state, m_valid);
      end
   endtask

   task automatic test_reset_in_score();
      bit found;
      found = 1'b0;
      pb = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.state_o == 3'd2) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rst_reach_score: S_SCORE not seen within 30 cycles");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd0 || bus.turn_o !== 4'd0) begin
         errors++; $display("FAIL rst_in_score: state %0d turn %0d expected 0 0", bus.state_o, bus.turn_o);
      end
      checks++;
      if ({bus.code_o, bus.guess_o, bus.positions_o, bus.numbers_o, bus.score_valid_o} !== '0) begin
         errors++; $display("FAIL rst_in_score_outputs: code %h guess %h pos %0d num %0d expected all 0",
                            bus.code_o, bus.guess_o, bus.positions_o, bus.numbers_o);
      end
      rst = 1'b0;
      pb = 1'b0;
      model_reset();
      repeat (12) @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd0 || valid_cycles != 0) begin
         errors++; $display("FAIL rst_press_lost: state %0d valid %0d expected 0 0", bus.state_o, valid_cycles);
      end
   endtask

   task automatic test_random_games();
      for (int it = 0; it < 40; it++) begin
         if (m_state == 1) begin
            gin = ($urandom_range(0, 3) == 0) ? m_code : 16'($urandom);
            use_forced = ($urandom_range(0, 3) == 0);
            f_pos = 8'($urandom_range(0, 5));
            f_num = 8'($urandom_range(0, 4));
         end else begin
            gin = 16'($urandom);
         end
         press();
         checks++;
         if (bus.state_o !== 3'(m_state) || bus.turn_o !== 4'(m_turn)) begin
            errors++; $display("FAIL rand_state[%0d]: state %0d turn %0d expected %0d %0d",
                               it, bus.state_o, bus.turn_o, m_state, m_turn);
         end
         checks++;
         if (bus.positions_o !== 8'(m_pos) || bus.numbers_o !== 8'(m_num)) begin
            errors++; $display("FAIL rand_score[%0d]: pos %0d num %0d expected %0d %0d",
                               it, bus.positions_o, bus.numbers_o, m_pos, m_num);
         end
         checks++;
         if (bus.code_o !== m_code || bus.guess_o !== m_guess) begin
            errors++; $display("FAIL rand_latch[%0d]: code %h guess %h expected %h %h",
                               it, bus.code_o, bus.guess_o, m_code, m_guess);
         end
         checks++;
         if (bus.lock_o !== (m_state == 3) || bus.lose_o !== (m_state == 4) || valid_cycles != m_valid) begin
            errors++; $display("FAIL rand_flags[%0d]: lock %b lose %b valid %0d expected %b %b %0d",
                               it, bus.lock_o, bus.lose_o, valid_cycles, m_state == 3, m_state == 4, m_valid);
         end
`ifdef MM_AUTOCODE_EN
         checks++;
         if (bus.code_o === 16'h0) begin
            errors++; $display("FAIL rand_autocode_zero[%0d]: got 0000 expected nonzero", it);
         end
`endif
      end
      use_forced = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_code_entry();
      test_win();
      test_lose();
      test_win_last_turn();
      test_bounce_in_score();
      test_reset_in_score();
      test_random_games();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
